hazard_scoreboard: RTL and testbench

//  Parametrised successor to the ID-stage load-use and control hazard logic, located in the ID stage.

---
 rtl/hazard_scoreboard_pkg.sv | 13 +
 rtl/hazard_scoreboard_if.sv | 21 ++
 rtl/hazard_scoreboard_reg_scoreboard.sv | 30 +++
 rtl/hazard_scoreboard.sv | 62 ++++++
 tb/tb_hazard_scoreboard.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_scoreboard_pkg.sv
// hazard_scoreboard_pkg: shared class/state encodings and default latencies for the ID hazard scoreboard
package hazard_scoreboard_pkg;
  localparam int DEF_NREG = 32;
  localparam int DEF_LOAD_LAT = 2;
  localparam int DEF_MD_LAT = 4;
  localparam int DEF_DRAIN = 3;
  localparam int DEF_CNT_W = 3;
  typedef enum logic [1:0] {CLS_NONE, CLS_ALU, CLS_LOAD, CLS_MD} cls_e;
  typedef enum logic [1:0] {HZ_RUN, HZ_DRAIN, HZ_HALTED} hz_state_e;
  function automatic int lat_of(cls_e c, int load_lat, int md_lat);
    return c == CLS_ALU ? 1 : c == CLS_LOAD ? load_lat : c == CLS_MD ? md_lat : 0;
  endfunction
endpackage

// File: rtl/hazard_scoreboard_if.sv
// hazard_scoreboard_if: ID-stage instruction descriptor in, stall/flush/status out
interface hazard_scoreboard_if
  import hazard_scoreboard_pkg::*;
#(parameter int NREG = DEF_NREG);
  localparam int REG_W = $clog2(NREG);
  logic i_id_valid, i_id_use_rs, i_id_use_rt, i_id_src_in_id, i_id_wr_en;
  logic i_id_is_halt, i_id_branch_taken, i_id_jump_taken;
  logic [REG_W-1:0] i_id_rs, i_id_rt, i_id_rd;
  cls_e i_id_class;
  logic o_stall, o_flush_id_ex, o_flush_if_id, o_md_busy, o_draining, o_halted;
  modport master (
    output i_id_valid, i_id_use_rs, i_id_use_rt, i_id_src_in_id, i_id_wr_en, i_id_is_halt,
           i_id_branch_taken, i_id_jump_taken, i_id_rs, i_id_rt, i_id_rd, i_id_class,
    input  o_stall, o_flush_id_ex, o_flush_if_id, o_md_busy, o_draining, o_halted
  );
  modport slave (
    input  i_id_valid, i_id_use_rs, i_id_use_rt, i_id_src_in_id, i_id_wr_en, i_id_is_halt,
           i_id_branch_taken, i_id_jump_taken, i_id_rs, i_id_rt, i_id_rd, i_id_class,
    output o_stall, o_flush_id_ex, o_flush_if_id, o_md_busy, o_draining, o_halted
  );
endinterface

// File: rtl/hazard_scoreboard_reg_scoreboard.sv
// reg_scoreboard: per-register in-flight countdown array with one write port and three read ports
module reg_scoreboard #(
  parameter int NREG = 32,
  parameter int CNT_W = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we_i,
  input  logic [$clog2(NREG)-1:0]  widx_i,
  input  logic [CNT_W-1:0]         wval_i,
  input  logic [$clog2(NREG)-1:0]  ra_i,
  input  logic [$clog2(NREG)-1:0]  rb_i,
  input  logic [$clog2(NREG)-1:0]  rc_i,
  output logic [CNT_W-1:0]         da_o,
  output logic [CNT_W-1:0]         db_o,
  output logic [CNT_W-1:0]         dc_o,
  output logic                     all_zero_o
);
  localparam int REG_W = $clog2(NREG);
  logic [NREG-1:0][CNT_W-1:0] cnt_q;
  always_ff @(posedge clk)
    for (int r = 0; r < NREG; r++)
      cnt_q[r] <= rst ? '0 : (we_i && widx_i == REG_W'(r)) ? wval_i : cnt_q[r] - CNT_W'(cnt_q[r] != '0);
  always_comb begin
    da_o = cnt_q[ra_i];
    db_o = cnt_q[rb_i];
    dc_o = cnt_q[rc_i];
    all_zero_o = cnt_q == '0;
  end
endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: ID-stage RAW/WAW/MD-structural stall, flush generation and HALT drain sequencing
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int NREG = DEF_NREG,
  parameter int LOAD_LAT = DEF_LOAD_LAT,
  parameter int MD_LAT = DEF_MD_LAT,
  parameter int DRAIN = DEF_DRAIN,
  parameter int CNT_W = DEF_CNT_W
) (
  input logic i_clk,
  input logic i_rst,
  hazard_scoreboard_if.slave hz
);
  localparam int DR_W = $clog2(DRAIN + 1);
  logic [CNT_W-1:0] cnt_rs, cnt_rt, cnt_rd, lat, md_cnt_q, md_cnt_d;
  logic [DR_W-1:0] drain_q;
  hz_state_e state_q;
  logic all_zero, use_rs, use_rt, raw_ex, raw_id, waw, md_struct, hazard, stall, issue, taken, we;
  reg_scoreboard #(.NREG(NREG), .CNT_W(CNT_W)) u_sb (
    .clk(i_clk), .rst(i_rst), .we_i(we), .widx_i(hz.i_id_rd), .wval_i(lat),
    .ra_i(hz.i_id_rs), .rb_i(hz.i_id_rt), .rc_i(hz.i_id_rd),
    .da_o(cnt_rs), .db_o(cnt_rt), .dc_o(cnt_rd), .all_zero_o(all_zero)
  );
  always_comb begin
    lat = CNT_W'(lat_of(hz.i_id_class, LOAD_LAT, MD_LAT));
    use_rs = hz.i_id_use_rs && hz.i_id_rs != '0;
    use_rt = hz.i_id_use_rt && hz.i_id_rt != '0;
    raw_ex = (use_rs && cnt_rs > CNT_W'(1)) || (use_rt && cnt_rt > CNT_W'(1));
    raw_id = hz.i_id_src_in_id && ((use_rs && cnt_rs != '0) || (use_rt && cnt_rt != '0));
    waw = hz.i_id_wr_en && hz.i_id_rd != '0 && cnt_rd > lat;
    md_struct = hz.i_id_class == CLS_MD && md_cnt_q != '0;
    hazard = hz.i_id_valid && (raw_ex || raw_id || waw || md_struct);
    stall = hazard || state_q != HZ_RUN;
    issue = hz.i_id_valid && !stall;
    taken = hz.i_id_branch_taken || hz.i_id_jump_taken;
    we = issue && hz.i_id_wr_en && hz.i_id_rd != '0;
    md_cnt_d = (issue && hz.i_id_class == CLS_MD) ? CNT_W'(MD_LAT - 1) : md_cnt_q - CNT_W'(md_cnt_q != '0);
    hz.o_stall = stall;
    hz.o_flush_id_ex = hazard && state_q == HZ_RUN;
    hz.o_flush_if_id = taken && !stall;
    hz.o_md_busy = md_cnt_q != '0;
    hz.o_draining = state_q == HZ_DRAIN;
    hz.o_halted = state_q == HZ_HALTED;
  end
  // a HALT sharing the cycle with a taken branch/jump is on the wrong path and is dropped
  always_ff @(posedge i_clk)
    if (i_rst) begin
      state_q <= HZ_RUN;
      drain_q <= '0;
      md_cnt_q <= '0;
    end else begin
      md_cnt_q <= md_cnt_d;
      if (state_q == HZ_RUN && issue && hz.i_id_is_halt && !taken) begin
        state_q <= HZ_DRAIN;
        drain_q <= DR_W'(DRAIN);
      end else if (state_q == HZ_DRAIN) begin
        drain_q <= drain_q - DR_W'(drain_q != '0);
        if (drain_q == '0 && all_zero && md_cnt_q == '0) state_q <= HZ_HALTED;
      end
    end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed scenarios plus random stimulus against a ready-time reference model
module tb_hazard_scoreboard;
  import hazard_scoreboard_pkg::*;
  localparam int NREG = DEF_NREG;
  localparam int REG_W = $clog2(NREG);
  localparam int LOAD_LAT = DEF_LOAD_LAT;
  localparam int MD_LAT = DEF_MD_LAT;
  localparam int DRAIN = DEF_DRAIN;
  logic clk = 0;
  logic rst = 0;
  always #5 clk = ~clk;
  hazard_scoreboard_if #(.NREG(NREG)) hz();
  hazard_scoreboard dut (.i_clk(clk), .i_rst(rst), .hz(hz));
  int checks = 0, errors = 0;
  logic v, urs, urt, inid, wr, halt, br, jp;
  int rs, rt, rd;
  cls_e cls;
  int now = 0, md_free = 0, st = 0, drain_end = 0;
  int ready [NREG];
  logic e_issue;
  logic [5:0] e_vec;
  function automatic int cnt_of(int r);
    return (r == 0 || ready[r] <= now) ? 0 : ready[r] - now;
  endfunction
  function automatic int lat_m(cls_e c);
    case (c)
      CLS_ALU: return 1;
      CLS_LOAD: return LOAD_LAT;
      CLS_MD: return MD_LAT;
      default: return 0;
    endcase
  endfunction
  function automatic logic [5:0] obs();
    return {hz.o_stall, hz.o_flush_id_ex, hz.o_flush_if_id, hz.o_md_busy, hz.o_draining, hz.o_halted};
  endfunction
  task automatic eval();
    logic rex, rid, waw, mds, h, s;
    rex = (urs && cnt_of(rs) > 1) || (urt && cnt_of(rt) > 1);
    rid = inid && ((urs && cnt_of(rs) > 0) || (urt && cnt_of(rt) > 0));
    waw = wr && rd != 0 && cnt_of(rd) > lat_m(cls);
    mds = cls == CLS_MD && md_free > now;
    h = v && (rex || rid || waw || mds);
    s = h || st != 0;
    e_issue = v && !s;
    e_vec = {s, h && st == 0, (br || jp) && !s, md_free > now, st == 1, st == 2};
  endtask
  task automatic drive();
    hz.i_id_valid = v; hz.i_id_use_rs = urs; hz.i_id_use_rt = urt; hz.i_id_src_in_id = inid;
    hz.i_id_wr_en = wr; hz.i_id_is_halt = halt; hz.i_id_branch_taken = br; hz.i_id_jump_taken = jp;
    hz.i_id_rs = REG_W'(rs); hz.i_id_rt = REG_W'(rt); hz.i_id_rd = REG_W'(rd); hz.i_id_class = cls;
    #1;
    eval();
  endtask
  task automatic tick();
    logic idle_all;
    eval();
    @(posedge clk);
    if (rst) begin
      foreach (ready[r]) ready[r] = 0;
      md_free = 0;
      st = 0;
    end else begin
      idle_all = 1;
      for (int r = 1; r < NREG; r++) if (cnt_of(r) != 0) idle_all = 0;
      if (e_issue && wr && rd != 0) ready[rd] = now + 1 + lat_m(cls);
      if (e_issue && cls == CLS_MD) md_free = now + MD_LAT;
      if (st == 0 && e_issue && halt && !(br || jp)) begin
        st = 1;
        drain_end = now + 1 + DRAIN;
      end else if (st == 1 && now >= drain_end && idle_all && md_free <= now) st = 2;
    end
    now++;
    @(negedge clk);
  endtask
  task automatic clr();
    v = 0; urs = 0; urt = 0; inid = 0; wr = 0; halt = 0; br = 0; jp = 0;
    rs = 0; rt = 0; rd = 0; cls = CLS_NONE;
  endtask
  task automatic idle(input int n);
    clr();
    repeat (n) begin drive(); tick(); end
  endtask
  task automatic run_instr(output int sn, output int fid, output int fif, output int mm);
    logic s;
    sn = 0; fid = 0; fif = 0; mm = 0;
    for (int i = 0; i < 30; i++) begin
      drive();
      if (obs() !== e_vec) mm++;
      s = hz.o_stall;
      sn += int'(s); fid += int'(hz.o_flush_id_ex); fif += int'(hz.o_flush_if_id);
      tick();
      if (s === 1'b0) begin clr(); return; end
    end
    sn = 99;
    clr();
  endtask

  task automatic test_reset();
    clr(); rst = 1;
    drive(); tick(); tick();
    rst = 0;
    drive();
    checks++;
    if (obs() !== 6'b0 || e_vec !== 6'b0) begin
      errors++; $display("FAIL reset outputs got=%b want=000000", obs());
    end
  endtask

  task automatic test_alu_forward();
    int sn, fid, fif, mm;
    idle(6);
    v = 1; wr = 1; rd = 3; cls = CLS_ALU; run_instr(sn, fid, fif, mm);
    v = 1; urs = 1; rs = 3; wr = 1; rd = 7; cls = CLS_ALU; run_instr(sn, fid, fif, mm);
    checks++;
    if (sn !== 0 || mm !== 0) begin errors++; $display("FAIL alu_ex_fwd stalls=%0d mism=%0d want 0/0", sn, mm); end
    v = 1; wr = 1; rd = 3; cls = CLS_ALU; run_instr(sn, fid, fif, mm);
    v = 1; urs = 1; rs = 3; inid = 1; run_instr(sn, fid, fif, mm);
    checks++;
    if (sn !== 1 || mm !== 0) begin errors++; $display("FAIL alu_id_use stalls=%0d mism=%0d want 1/0", sn, mm); end
  endtask

  task automatic test_load_use();
    int sn, fid, fif, mm;
    idle(6);
    v = 1; wr = 1; rd = 4; cls = CLS_LOAD; run_instr(sn, fid, fif, mm);
    v = 1; urt = 1; rt = 4; wr = 1; rd = 9; cls = CLS_ALU; run_instr(sn, fid, fif, mm);
    checks++;
    if (sn !== 1 || fid !== 1 || mm !== 0) begin
      errors++; $display("FAIL load_use_ex stalls=%0d flush=%0d mism=%0d want 1/1/0", sn, fid, mm);
    end
    idle(4);
    v = 1; wr = 1; rd = 4; cls = CLS_LOAD; run_instr(sn, fid, fif, mm);
    v = 1; urs = 1; rs = 4; inid = 1; run_instr(sn, fid, fif, mm);
    checks++;
    if (sn !== 2 || fid !== 2 || mm !== 0) begin
      errors++; $display("FAIL load_use_id stalls=%0d flush=%0d mism=%0d want 2/2/0", sn, fid, mm);
    end
  endtask

  task automatic test_md();
    int sn, fid, fif, mm;
    idle(6);
    v = 1; wr = 1; rd = 5; cls = CLS_MD; run_instr(sn, fid, fif, mm);
    drive();
    checks++;
    if (hz.o_md_busy !== 1'b1) begin errors++; $display("FAIL md_busy got=%b want=1", hz.o_md_busy); end
    v = 1; wr = 1; rd = 8; cls = CLS_MD; run_instr(sn, fid, fif, mm);
    checks++;
    if (sn !== 3 || mm !== 0) begin errors++; $display("FAIL md_struct stalls=%0d mism=%0d want 3/0", sn, mm); end
    idle(6);
    v = 1; wr = 1; rd = 5; cls = CLS_MD; run_instr(sn, fid, fif, mm);
    v = 1; wr = 1; rd = 5; cls = CLS_ALU; run_instr(sn, fid, fif, mm);
    checks++;
    if (sn !== 3 || mm !== 0) begin errors++; $display("FAIL waw stalls=%0d mism=%0d want 3/0", sn, mm); end
  endtask

  task automatic test_branch();
    int sn, fid, fif, mm;
    idle(6);
    v = 1; urs = 1; rs = 9; inid = 1; br = 1; run_instr(sn, fid, fif, mm);
    checks++;
    if (sn !== 0 || fif !== 1 || mm !== 0) begin
      errors++; $display("FAIL branch_free stalls=%0d flush_if_id=%0d mism=%0d want 0/1/0", sn, fif, mm);
    end
    v = 1; wr = 1; rd = 4; cls = CLS_LOAD; run_instr(sn, fid, fif, mm);
    v = 1; urs = 1; rs = 4; inid = 1; br = 1; run_instr(sn, fid, fif, mm);
    checks++;
    if (sn !== 2 || fif !== 1 || mm !== 0) begin
      errors++; $display("FAIL branch_stalled stalls=%0d flush_if_id=%0d mism=%0d want 2/1/0", sn, fif, mm);
    end
    v = 1; jp = 1; halt = 1; run_instr(sn, fid, fif, mm);
    drive();
    checks++;
    if (hz.o_draining !== 1'b0 || fif !== 1) begin
      errors++; $display("FAIL halt_with_jump draining=%b flush_if_id=%0d want 0/1", hz.o_draining, fif);
    end
  endtask

  task automatic test_halt();
    int sn, fid, fif, mm, n, bad;
    idle(6);
    v = 1; wr = 1; rd = 2; cls = CLS_LOAD; run_instr(sn, fid, fif, mm);
    v = 1; halt = 1; run_instr(sn, fid, fif, mm);
    n = 0; bad = mm;
    for (int i = 0; i < 50; i++) begin
      drive();
      if (obs() !== e_vec) bad++;
      if (hz.o_halted === 1'b1) break;
      if (hz.o_draining === 1'b1) n++;
      tick();
    end
    checks++;
    if (n !== DRAIN + 1 || hz.o_halted !== 1'b1 || bad !== 0) begin
      errors++; $display("FAIL drain_len cycles=%0d halted=%b mism=%0d want %0d/1/0", n, hz.o_halted, bad, DRAIN + 1);
    end
    bad = 0;
    v = 1; wr = 1; rd = 6; cls = CLS_ALU;
    repeat (5) begin
      drive();
      if (hz.o_halted !== 1'b1 || hz.o_stall !== 1'b1 || obs() !== e_vec) bad++;
      tick();
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL halted_sticky bad_cycles=%0d want 0", bad); end
    clr(); rst = 1; drive(); tick(); rst = 0;
    v = 1; halt = 1; run_instr(sn, fid, fif, mm);
    idle(2);
    drive();
    checks++;
    if (hz.o_draining !== 1'b1 || hz.o_stall !== 1'b1) begin
      errors++; $display("FAIL drain_entry draining=%b stall=%b want 1/1", hz.o_draining, hz.o_stall);
    end
    rst = 1; drive(); tick(); rst = 0;
    drive();
    checks++;
    if (obs() !== 6'b0) begin errors++; $display("FAIL reset_mid_drain got=%b want=000000", obs()); end
  endtask

  task automatic test_r0();
    int sn, fid, fif, mm, tot;
    idle(6);
    v = 1; wr = 1; rd = 0; cls = CLS_LOAD; run_instr(sn, fid, fif, mm);
    tot = sn;
    v = 1; urs = 1; rs = 0; urt = 1; rt = 0; inid = 1; wr = 1; rd = 0; cls = CLS_ALU; run_instr(sn, fid, fif, mm);
    tot += sn;
    v = 1; wr = 1; rd = 4; cls = CLS_LOAD; run_instr(sn, fid, fif, mm);
    tot += sn;
    v = 1; urt = 0; rt = 4; urs = 1; rs = 0; inid = 1; run_instr(sn, fid, fif, mm);
    tot += sn;
    checks++;
    if (tot !== 0 || mm !== 0) begin errors++; $display("FAIL r0_unused stalls=%0d mism=%0d want 0/0", tot, mm); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      v = $urandom_range(0, 3) != 0;
      urs = $urandom_range(0, 1) == 1; urt = $urandom_range(0, 1) == 1;
      inid = $urandom_range(0, 3) == 0; wr = $urandom_range(0, 3) != 0;
      rs = $urandom_range(0, 7); rt = $urandom_range(0, 7); rd = $urandom_range(0, 7);
      cls = cls_e'($urandom_range(0, 3));
      halt = $urandom_range(0, 40) == 0;
      br = $urandom_range(0, 5) == 0; jp = $urandom_range(0, 9) == 0;
      rst = $urandom_range(0, 60) == 0;
      drive();
      checks++;
      if (obs() !== e_vec) begin
        errors++; $display("FAIL random cycle=%0d got=%b want=%b", i, obs(), e_vec);
      end
      tick();
    end
    rst = 0;
  endtask

  initial begin
    test_reset();
    test_alu_forward();
    test_load_use();
    test_md();
    test_branch();
    test_halt();
    test_r0();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
